mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Memory-stage access controller for the pipelined LC-3b datapath. It consumes the outputs of the EX/MEM pipeline register, sequences data-memory reads and writes (including the two-access LDI/STI indirection), formats byte/word data, and raises a stall that freezes all upstream pipeline registers until the access completes. Its load-data and done outputs feed the MEM/WB register.

## Interface
- No parameters; all widths are fixed (word = 16 bits).
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- mem_valid  in  1  instruction in MEM stage is valid (not a bubble)
- mem_read  in  1  instruction performs a final load
- mem_write  in  1  instruction performs a final store (never both with mem_read)
- mem_byte  in  1  final access is byte-sized (LDB/STB)
- mem_indirect  in  1  LDI/STI: first read pointer word, then access at pointer
- mem_address  in  16  effective address from EX/MEM register
- mem_store_data  in  16  source-register value for stores
- dmem_rdata  in  16  data-memory read data, valid when dmem_resp=1
- dmem_resp  in  1  data-memory completion, one cycle per access
- dmem_address  out  16  data-memory address
- dmem_read  out  1  read request, held until dmem_resp
- dmem_write  out  1  write request, held until dmem_resp
- dmem_wmask  out  2  byte enables (bit1 = high byte)
- dmem_wdata  out  16  write data
- mem_stall  out  1  freeze upstream pipeline registers (deassert their load)
- mem_done  out  1  access sequence completes this cycle
- mem_load_data  out  16  formatted load result, valid when mem_done=1
- stall_count  out  16  saturating count of cycles with mem_stall=1

## Operation
- req = mem_valid & (mem_read | mem_write). No req: no dmem request, mem_stall=0, mem_done=0.
- States: IDLE, FINAL. Registered pointer ptr (16 b).
- IDLE, req, mem_indirect=1: issue word read at {mem_address[15:1],0}. On dmem_resp: ptr <= dmem_rdata, go FINAL.
- IDLE, req, mem_indirect=0: issue final access at mem_address. On dmem_resp: mem_done=1, stay IDLE.
- FINAL: issue final access at ptr. On dmem_resp: mem_done=1, go IDLE. If mem_valid drops (flush) in FINAL: no request, go IDLE next edge.
- Final access formatting (A = address used):
  - Word: dmem_address={A[15:1],0}, wmask=11, wdata=mem_store_data; load data = dmem_rdata.
  - Byte: dmem_address=A, wdata={sd[7:0],sd[7:0]}, wmask = A[0] ? 10 : 01; load data = sign-extend of dmem_rdata[15:8] if A[0] else dmem_rdata[7:0].
  - Indirect is word-only; mem_byte ignored when mem_indirect=1.
- Pointer read always dmem_read=1, wmask=11.
- dmem_wmask=00 and dmem_wdata=0 whenever dmem_write=0.
- mem_stall = req & ~mem_done (combinational).
- stall_count increments each edge with mem_stall=1; holds at 0xFFFF.

## Timing
- Reset (asynchronous): state=IDLE, ptr=0, stall_count=0. While reset=1: dmem_read, dmem_write, mem_stall, mem_done forced 0; mem_load_data=0.
- Reset mid-sequence (state FINAL): abandons access; restarts from IDLE after release if req still present.
- Request outputs combinational from state and inputs; same-cycle dmem_resp allowed.
- Direct access: 1 + memory latency cycles; stall released in the dmem_resp cycle, so EX/MEM loads the next instruction at that edge and a back-to-back access issues in the following cycle without an idle cycle.
- Indirect: two accesses; minimum 2 cycles (resp each cycle), stall high in first.
- mem_load_data combinational from dmem_rdata; MEM/WB captures it on the mem_done edge.

## Test plan
- LDW addr 0x3001, rdata 0xBEEF, resp after 2 cycles -> dmem_address 0x3000, read held 3 cycles, stall 2 cycles, done with load 0xBEEF, stall_count=2.
- LDB addr 0x3001, rdata 0x80_12 -> load 0xFF80; addr 0x3000 -> load 0x0012.
- STB addr 0x4001, store 0x1234 -> wdata 0x3434, wmask 10; STW addr 0x4001 -> address 0x4000, wmask 11.
- LDI addr 0x5000, first rdata 0x6002, second rdata 0xCAFE, resp same-cycle -> second address 0x6002, done cycle 2, load 0xCAFE.
- Reset asserted in FINAL of STI -> dmem_write drops immediately, ptr=0, stall_count=0; after release, sequence restarts with pointer read.
- Bubble (mem_valid=0, mem_read=1) -> no request, stall 0; 70000 stall cycles -> stall_count saturates at 0xFFFF.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller for the pipelined LC-3b datapath.
// Sequences direct and indirect (LDI/STI) data-memory accesses, formats
// byte/word data, and stalls the upstream pipeline until each access completes.
module mem_access_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_byte,
    input  logic        mem_indirect,
    input  logic [15:0] mem_address,
    input  logic [15:0] mem_store_data,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic [15:0] dmem_address,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [1:0]  dmem_wmask,
    output logic [15:0] dmem_wdata,
    output logic        mem_stall,
    output logic        mem_done,
    output logic [15:0] mem_load_data,
    output logic [15:0] stall_count
);

    typedef enum logic {IDLE, FINAL} state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] ptr;
    logic        ptr_load;
    logic        req;
    logic        acc_final;
    logic        acc_byte;
    logic [15:0] acc_addr;
    logic [7:0]  byte_sel;

    assign req = mem_valid & (mem_read | mem_write);

    // Stall whenever a live memory instruction has not finished this cycle.
    assign mem_stall = req & ~mem_done & ~reset;

    // State and pointer registers; reset abandons any in-flight sequence.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= 16'h0000;
        end else begin
            state <= state_next;
            if (ptr_load) begin
                ptr <= dmem_rdata;
            end
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= 16'h0000;
        end else if (mem_stall && stall_count != 16'hFFFF) begin
            stall_count <= stall_count + 16'h0001;
        end
    end

    // Next-state, request generation and load formatting.
    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next    = state;
        ptr_load      = 1'b0;
        acc_final     = 1'b0;
        acc_byte      = 1'b0;
        acc_addr      = mem_address;
        byte_sel      = 8'h00;
        dmem_address  = 16'h0000;
        dmem_read     = 1'b0;
        dmem_write    = 1'b0;
        dmem_wmask    = 2'b00;
        dmem_wdata    = 16'h0000;
        mem_done      = 1'b0;
        mem_load_data = 16'h0000;

        case (state)
            IDLE: begin
                if (req) begin
                    if (mem_indirect) begin
                        // Pointer fetch: always a word read.
                        dmem_read    = 1'b1;
                        dmem_address = {mem_address[15:1], 1'b0};
                        if (dmem_resp) begin
                            ptr_load   = 1'b1;
                            state_next = FINAL;
                        end
                    end else begin
                        acc_final = 1'b1;
                        acc_addr  = mem_address;
                        acc_byte  = mem_byte;
                    end
                end
            end
            FINAL: begin
                if (req) begin
                    // Indirect final access is word-sized at the fetched pointer.
                    acc_final = 1'b1;
                    acc_addr  = ptr;
                    acc_byte  = 1'b0;
                    if (dmem_resp) begin
                        state_next = IDLE;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (acc_final) begin
            dmem_read    = mem_read;
            dmem_write   = mem_write;
            dmem_address = acc_byte ? acc_addr : {acc_addr[15:1], 1'b0};
            if (mem_write) begin
                dmem_wmask = acc_byte ? (acc_addr[0] ? 2'b10 : 2'b01) : 2'b11;
                dmem_wdata = acc_byte ? {mem_store_data[7:0], mem_store_data[7:0]}
                                      : mem_store_data;
            end
            mem_done = dmem_resp;
            if (dmem_resp) begin
                byte_sel      = acc_addr[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];
                mem_load_data = acc_byte ? {{8{byte_sel[7]}}, byte_sel} : dmem_rdata;
            end
        end

        if (reset) begin
            ptr_load      = 1'b0;
            dmem_read     = 1'b0;
            dmem_write    = 1'b0;
            dmem_wmask    = 2'b00;
            dmem_wdata    = 16'h0000;
            mem_done      = 1'b0;
            mem_load_data = 16'h0000;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios with literal
// expectations, then randomized instructions checked every cycle against an
// access-list reference model.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid, mem_read, mem_write, mem_byte, mem_indirect;
    logic [15:0] mem_address, mem_store_data, dmem_rdata;
    logic        dmem_resp;
    logic [15:0] dmem_address, dmem_wdata, mem_load_data, stall_count;
    logic        dmem_read, dmem_write, mem_stall, mem_done;
    logic [1:0]  dmem_wmask;

    int n_checks = 0;
    int n_bad    = 0;

    // Reference model: index into the instruction's access list
    // (indirect: [pointer read, final]; direct: [final]).
    int          m_step = 0;
    logic [15:0] m_ptr  = 16'h0000;
    int          m_cnt  = 0;
    bit          m_done = 1'b0;

    mem_access_ctrl dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte(mem_byte), .mem_indirect(mem_indirect),
        .mem_address(mem_address), .mem_store_data(mem_store_data),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
        .mem_stall(mem_stall), .mem_done(mem_done),
        .mem_load_data(mem_load_data), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] sext8(input logic [7:0] b);
        return {{8{b[7]}}, b};
    endfunction

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin : compare
        logic        req, fin, byt;
        logic [15:0] a, e_addr, e_wdata, e_load;
        logic [1:0]  e_mask;
        logic        e_read, e_write, e_done;
        if (reset) begin
            check("rst_read", {15'b0, dmem_read}, 16'h0);
            check("rst_write", {15'b0, dmem_write}, 16'h0);
            check("rst_stall", {15'b0, mem_stall}, 16'h0);
            check("rst_done", {15'b0, mem_done}, 16'h0);
            check("rst_load", mem_load_data, 16'h0);
            check("rst_count", stall_count, 16'h0);
            m_step = 0; m_ptr = 16'h0; m_cnt = 0; m_done = 0;
        end else begin
            check("stall_count", stall_count, m_cnt[15:0]);
            req = mem_valid & (mem_read | mem_write);
            e_read = 0; e_write = 0; e_addr = 16'h0; e_mask = 2'b00;
            e_wdata = 16'h0; e_done = 0; e_load = 16'h0; fin = 0; byt = 0; a = 16'h0;
            if (!req) begin
                m_step = 0;
            end else if (mem_indirect && m_step == 0) begin
                e_read = 1; e_addr = mem_address & 16'hFFFE;
            end else begin
                fin = 1;
                a   = mem_indirect ? m_ptr : mem_address;
                byt = mem_byte & ~mem_indirect;
                e_read  = mem_read;
                e_write = mem_write;
                e_addr  = byt ? a : (a & 16'hFFFE);
                if (mem_write) begin
                    e_mask  = byt ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
                    e_wdata = byt ? {2{mem_store_data[7:0]}} : mem_store_data;
                end
                e_done = dmem_resp;
                e_load = !byt ? dmem_rdata
                       : (a[0] ? sext8(dmem_rdata[15:8]) : sext8(dmem_rdata[7:0]));
            end
            check("dmem_read", {15'b0, dmem_read}, {15'b0, e_read});
            check("dmem_write", {15'b0, dmem_write}, {15'b0, e_write});
            check("dmem_wmask", {14'b0, dmem_wmask}, {14'b0, e_mask});
            check("dmem_wdata", dmem_wdata, e_wdata);
            check("mem_done", {15'b0, mem_done}, {15'b0, e_done});
            check("mem_stall", {15'b0, mem_stall}, {15'b0, req & ~e_done});
            if (e_read || e_write) check("dmem_address", dmem_address, e_addr);
            if (e_done && mem_read) check("mem_load_data", mem_load_data, e_load);
            // Advance model for the next cycle.
            if (req && !fin && dmem_resp) begin
                m_ptr = dmem_rdata; m_step = 1;
            end
            if (fin && dmem_resp) m_step = 0;
            if (req && !e_done && m_cnt < 16'hFFFF) m_cnt++;
            m_done = e_done;
        end
    end

    task automatic to_neg(); @(negedge clk); #1; endtask
    task automatic to_pos(); @(posedge clk); #1; endtask

    task automatic set_instr(input logic v, r, w, b, ind, input logic [15:0] a, sd);
        mem_valid = v; mem_read = r; mem_write = w; mem_byte = b;
        mem_indirect = ind; mem_address = a; mem_store_data = sd;
    endtask

    initial begin
        bit done_flag, flushed;
        logic v, r, b, ind;
        reset = 1'b1; dmem_resp = 0; dmem_rdata = 16'h0;
        set_instr(0, 0, 0, 0, 0, 16'h0, 16'h0);
        repeat (2) to_pos();
        reset = 1'b0;

        // LDW 0x3001, response after two wait cycles.
        set_instr(1, 1, 0, 0, 0, 16'h3001, 16'h0); dmem_rdata = 16'hBEEF;
        to_neg();
        check("ldw_addr", dmem_address, 16'h3000);
        check("ldw_read0", {15'b0, dmem_read}, 16'h1);
        check("ldw_stall0", {15'b0, mem_stall}, 16'h1);
        to_pos(); to_neg();
        check("ldw_read1", {15'b0, dmem_read}, 16'h1);
        check("ldw_stall1", {15'b0, mem_stall}, 16'h1);
        to_pos(); dmem_resp = 1; to_neg();
        check("ldw_read2", {15'b0, dmem_read}, 16'h1);
        check("ldw_done", {15'b0, mem_done}, 16'h1);
        check("ldw_stall2", {15'b0, mem_stall}, 16'h0);
        check("ldw_load", mem_load_data, 16'hBEEF);
        to_pos();

        // LDB high and low byte, back-to-back.
        set_instr(1, 1, 0, 1, 0, 16'h3001, 16'h0); dmem_rdata = 16'h8012; dmem_resp = 1;
        to_neg(); check("ldb_hi_addr", dmem_address, 16'h3001);
        check("ldb_hi_load", mem_load_data, 16'hFF80);
        to_pos(); mem_address = 16'h3000;
        to_neg(); check("ldb_lo_load", mem_load_data, 16'h0012);
        check("count_after_ldw", stall_count, 16'h0002);
        to_pos();

        // STB / STW at odd address.
        set_instr(1, 0, 1, 1, 0, 16'h4001, 16'h1234);
        to_neg(); check("stb_wdata", dmem_wdata, 16'h3434);
        check("stb_wmask", {14'b0, dmem_wmask}, 16'h2);
        to_pos(); mem_byte = 0;
        to_neg(); check("stw_addr", dmem_address, 16'h4000);
        check("stw_wmask", {14'b0, dmem_wmask}, 16'h3);
        check("stw_wdata", dmem_wdata, 16'h1234);
        to_pos();

        // LDI with same-cycle responses.
        set_instr(1, 1, 0, 0, 1, 16'h5000, 16'h0); dmem_rdata = 16'h6002;
        to_neg(); check("ldi_ptr_addr", dmem_address, 16'h5000);
        check("ldi_stall", {15'b0, mem_stall}, 16'h1);
        check("ldi_done0", {15'b0, mem_done}, 16'h0);
        to_pos(); dmem_rdata = 16'hCAFE;
        to_neg(); check("ldi_final_addr", dmem_address, 16'h6002);
        check("ldi_done1", {15'b0, mem_done}, 16'h1);
        check("ldi_load", mem_load_data, 16'hCAFE);
        to_pos();

        // STI interrupted by reset in the final phase.
        set_instr(1, 0, 1, 0, 1, 16'h5000, 16'h1111); dmem_rdata = 16'h7000;
        to_neg(); to_pos(); dmem_resp = 0;
        to_neg(); check("sti_write", {15'b0, dmem_write}, 16'h1);
        check("sti_addr", dmem_address, 16'h7000);
        reset = 1'b1; #1;
        check("sti_rst_write", {15'b0, dmem_write}, 16'h0);
        check("sti_rst_count", stall_count, 16'h0);
        to_pos(); to_neg(); to_pos();
        reset = 1'b0; dmem_resp = 1; dmem_rdata = 16'h7000;
        to_neg(); check("sti_restart_read", {15'b0, dmem_read}, 16'h1);
        check("sti_restart_addr", dmem_address, 16'h5000);
        check("sti_restart_write", {15'b0, dmem_write}, 16'h0);
        to_pos();
        to_neg(); check("sti_final_done", {15'b0, mem_done}, 16'h1);
        to_pos();

        // Bubble.
        set_instr(0, 1, 0, 0, 0, 16'h1234, 16'h0); dmem_resp = 0;
        to_neg(); check("bubble_read", {15'b0, dmem_read}, 16'h0);
        check("bubble_stall", {15'b0, mem_stall}, 16'h0);
        to_pos();

        // Randomized instruction stream.
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 6) != 0); r = $urandom_range(0, 1);
            b = $urandom_range(0, 1); ind = ($urandom_range(0, 2) == 0);
            set_instr(v, r, ~r, b, ind, 16'($urandom), 16'($urandom));
            dmem_rdata = 16'($urandom);
            if (!v) begin
                dmem_resp = $urandom_range(0, 1);
                to_neg(); to_pos();
                continue;
            end
            done_flag = 0; flushed = 0;
            for (int c = 0; c < 64 && !done_flag && !flushed; c++) begin
                dmem_rdata = 16'($urandom);
                if (ind && m_step == 1 && $urandom_range(0, 5) == 0) begin
                    mem_valid = 0; dmem_resp = 0;
                    to_neg(); to_pos();
                    flushed = 1;
                end else begin
                    dmem_resp = (c > 20) || ($urandom_range(0, 2) == 0);
                    to_neg(); done_flag = m_done; to_pos();
                end
            end
            check("seq_complete", {15'b0, done_flag | flushed}, 16'h1);
        end

        // Saturation of the stall counter.
        reset = 1'b1; to_neg(); to_pos(); reset = 1'b0;
        set_instr(1, 1, 0, 0, 0, 16'h2000, 16'h0); dmem_resp = 0;
        repeat (70000) to_pos();
        to_neg(); check("count_saturated", stall_count, 16'hFFFF);
        to_pos(); dmem_resp = 1;
        to_neg(); check("sat_done", {15'b0, mem_done}, 16'h1);
        to_pos(); set_instr(0, 0, 0, 0, 0, 16'h0, 16'h0); dmem_resp = 0;
        to_neg(); check("count_hold", stall_count, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
